// File: rtl/dense_mac_pkg.sv
// Shared types, fixed-point defaults and helper functions for the dense MAC engine.
package dense_mac_pkg;

  // Fixed-point defaults: Q6.10 in a 16-bit word.
  localparam int unsigned DEF_DATA_W = 16;
  localparam int unsigned DEF_FRAC   = 10;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StAccum = 2'd1,
    StOut   = 2'd2
  } state_e;

  function automatic int unsigned ceil_div(input int unsigned a, input int unsigned b);
    return (a + b - 1) / b;
  endfunction

  // Clamp a signed value into the range of a signed 'width'-bit word.
  function automatic logic signed [63:0] sat_to_width(input logic signed [63:0] value,
                                                      input int unsigned       width);
    logic signed [63:0] max_v;
    logic signed [63:0] min_v;
    max_v = (64'sd1 <<< (width - 1)) - 64'sd1;
    min_v = -(64'sd1 <<< (width - 1));
    if (value > max_v) begin
      return max_v;
    end
    if (value < min_v) begin
      return min_v;
    end
    return value;
  endfunction

endpackage

// File: rtl/dense_mac_lanes.sv
// Combinational LANES-wide multiply, fixed-point shift, tail mask and sum for one beat.
module dense_mac_lanes
  import dense_mac_pkg::*;
#(
  parameter int unsigned LANES  = 3,
  parameter int unsigned N_IN   = 8,
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned FRAC   = DEF_FRAC,
  parameter int unsigned ACC_W  = 32,
  parameter int unsigned BEAT_W = 2
) (
  input  logic        [BEAT_W-1:0]            beat,
  input  logic signed [LANES-1:0][DATA_W-1:0] in_data,
  input  logic signed [LANES-1:0][DATA_W-1:0] w_data,
  output logic signed [ACC_W-1:0]             lane_sum
);

  // Products are formed at full width so the shift sees every bit before narrowing.
  localparam int unsigned PROD_W = (ACC_W > 2 * DATA_W) ? ACC_W : 2 * DATA_W;

  // Sum of shifted lane products; lanes past the last input of the neuron are dropped.
  always_comb begin
    logic signed [PROD_W-1:0] prod;
    prod     = '0;
    lane_sum = '0;
    for (int l = 0; l < int'(LANES); l++) begin
      prod = PROD_W'($signed(in_data[l])) * PROD_W'($signed(w_data[l]));
      if (int'(beat) * int'(LANES) + l < int'(N_IN)) begin
        lane_sum = lane_sum + ACC_W'(prod >>> FRAC);
      end
    end
  end

endmodule

// File: rtl/dense_mac_engine.sv
// Dense-layer neuron engine: streams activation beats, accumulates weighted sums per neuron,
// adds bias, saturates and emits one result per neuron.
// Optional macro DENSE_MAC_RELU_EN clamps negative results to zero.
module dense_mac_engine
  import dense_mac_pkg::*;
#(
  parameter  int unsigned LANES     = 3,
  parameter  int unsigned N_IN      = 8,
  parameter  int unsigned N_NEURONS = 16,
  parameter  int unsigned DATA_W    = DEF_DATA_W,
  parameter  int unsigned FRAC      = DEF_FRAC,
  parameter  int unsigned ACC_W     = 32,
  localparam int unsigned ADDR_W    = (N_NEURONS * N_IN > 1) ? $clog2(N_NEURONS * N_IN) : 1,
  localparam int unsigned IDX_W     = (N_NEURONS > 1) ? $clog2(N_NEURONS) : 1
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               start,
  input  logic                               in_valid,
  output logic                               in_ready,
  input  logic signed [LANES-1:0][DATA_W-1:0] in_data,
  output logic        [ADDR_W-1:0]           w_addr,
  input  logic signed [LANES-1:0][DATA_W-1:0] w_data,
  input  logic signed [DATA_W-1:0]           bias,
  output logic        [IDX_W-1:0]            neuron_idx,
  output logic                               out_valid,
  input  logic                               out_ready,
  output logic signed [DATA_W-1:0]           out_data,
  output logic                               out_last,
  output logic                               busy
);

  localparam int unsigned BEATS  = ceil_div(N_IN, LANES);
  localparam int unsigned BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [BEAT_W-1:0] LAST_BEAT   = BEAT_W'(BEATS - 1);
  localparam logic [IDX_W-1:0]  LAST_NEURON = IDX_W'(N_NEURONS - 1);

  state_e                    state_q, state_d;
  logic signed [ACC_W-1:0]   acc_q, acc_d;
  logic        [BEAT_W-1:0]  beat_q, beat_d;
  logic        [IDX_W-1:0]   neuron_q, neuron_d;
  logic                      out_valid_q, out_valid_d;
  logic                      out_last_q, out_last_d;
  logic signed [DATA_W-1:0]  out_data_q, out_data_d;

  logic signed [ACC_W-1:0]   lane_sum;
  logic signed [ACC_W-1:0]   acc_next;
  logic signed [ACC_W-1:0]   biased;
  logic signed [DATA_W-1:0]  sat_val;
  logic signed [DATA_W-1:0]  result;
  logic                      accept;

  dense_mac_lanes #(
    .LANES  (LANES),
    .N_IN   (N_IN),
    .DATA_W (DATA_W),
    .FRAC   (FRAC),
    .ACC_W  (ACC_W),
    .BEAT_W (BEAT_W)
  ) u_lanes (
    .beat     (beat_q),
    .in_data  (in_data),
    .w_data   (w_data),
    .lane_sum (lane_sum)
  );

  assign in_ready   = (state_q == StAccum);
  assign busy       = (state_q != StIdle);
  assign accept     = in_valid & in_ready;
  assign neuron_idx = neuron_q;
  assign out_valid  = out_valid_q;
  assign out_last   = out_last_q;
  assign out_data   = out_data_q;
  assign w_addr     = ADDR_W'(int'(neuron_q) * int'(N_IN) + int'(beat_q) * int'(LANES));

  // Accumulator wraps at ACC_W; only the final biased value is saturated.
  assign acc_next = acc_q + lane_sum;
  assign biased   = acc_next + ACC_W'(bias);
  assign sat_val  = DATA_W'(sat_to_width(64'(biased), DATA_W));

`ifdef DENSE_MAC_RELU_EN
  assign result = sat_val[DATA_W-1] ? '0 : sat_val;
`else
  assign result = sat_val;
`endif

  // Next-state logic for the pass sequencer, beat counter and output register.
  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    beat_d      = beat_q;
    neuron_d    = neuron_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    out_data_d  = out_data_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d  = StAccum;
          neuron_d = '0;
          acc_d    = '0;
          beat_d   = '0;
        end
      end
      StAccum: begin
        if (accept) begin
          if (beat_q == LAST_BEAT) begin
            out_data_d  = result;
            out_valid_d = 1'b1;
            out_last_d  = (neuron_q == LAST_NEURON);
            acc_d       = '0;
            beat_d      = '0;
            state_d     = StOut;
          end else begin
            acc_d  = acc_next;
            beat_d = beat_q + BEAT_W'(1);
          end
        end
      end
      StOut: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          out_last_d  = 1'b0;
          if (out_last_q) begin
            neuron_d = '0;
            state_d  = StIdle;
          end else begin
            neuron_d = neuron_q + IDX_W'(1);
            state_d  = StAccum;
          end
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State registers; reset discards any partial sum.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= StIdle;
      acc_q       <= '0;
      beat_q      <= '0;
      neuron_q    <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      beat_q      <= beat_d;
      neuron_q    <= neuron_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      out_data_q  <= out_data_d;
    end
  end

endmodule

// File: tb/tb_dense_mac_engine.sv
// Directed self-checking bench for dense_mac_engine (default parameters).
module tb_dense_mac_engine;

  logic                    clk;
  logic                    reset;
  logic                    start;
  logic                    in_valid;
  logic                    in_ready;
  logic signed [2:0][15:0] in_data;
  logic        [6:0]       w_addr;
  logic signed [2:0][15:0] w_data;
  logic signed [15:0]      bias;
  logic        [3:0]       neuron_idx;
  logic                    out_valid;
  logic                    out_ready;
  logic signed [15:0]      out_data;
  logic                    out_last;
  logic                    busy;

  int n_checks = 0;
  int n_errors = 0;

  // Weight source: constant value, or weight equal to its flat index.
  logic               w_index_mode;
  logic               w_ov_en;
  logic signed [15:0] w_val;

  dense_mac_engine u_dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .w_addr     (w_addr),
    .w_data     (w_data),
    .bias       (bias),
    .neuron_idx (neuron_idx),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_last   (out_last),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Weight memory model, combinational on w_addr.
  always_comb begin
    for (int l = 0; l < 3; l++) begin
      if (w_index_mode) w_data[l] = 16'(int'(w_addr) + l);
      else              w_data[l] = w_val;
      if (w_ov_en && (int'(w_addr) % 8 == 6) && l == 2) w_data[l] = 16'(30000);
    end
  end

  task automatic check_eq(input string tag, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
    end
  endtask

  function automatic int relu_exp(input int v);
`ifdef DENSE_MAC_RELU_EN
    return (v < 0) ? 0 : v;
`else
    return v;
`endif
  endfunction

  // Present nbeats beats of neuron n; beat-2 lane-2 carries ov. Ends on the negedge after
  // the last accepting edge.
  task automatic feed(input int n, input int dval, input int ov, input int nbeats,
                      input bit rnd);
    int sent;
    int cyc;
    sent = 0;
    cyc  = 0;
    while (sent < nbeats && cyc < 200) begin
      in_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      for (int l = 0; l < 3; l++) in_data[l] = 16'((sent == 2 && l == 2) ? ov : dval);
      if (in_valid && in_ready) begin
        check_eq($sformatf("n%0d_waddr_b%0d", n, sent), int'(w_addr), n * 8 + 3 * sent);
        sent++;
      end
      @(negedge clk);
      cyc++;
    end
    in_valid = 1'b0;
    check_eq($sformatf("n%0d_beats_accepted", n), sent, nbeats);
  endtask

  // Expect the result now, optionally stall for hold cycles, then hand it off.
  task automatic take_out(input int n, input int exp, input bit exp_last, input int hold);
    int cyc;
    cyc = 0;
    while (!out_valid && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    check_eq($sformatf("n%0d_latency", n), cyc, 0);
    check_eq($sformatf("n%0d_data", n), int'(out_data), exp);
    check_eq($sformatf("n%0d_last", n), int'(out_last), int'(exp_last));
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      check_eq($sformatf("n%0d_hold%0d_valid", n, h), int'(out_valid), 1);
      check_eq($sformatf("n%0d_hold%0d_data", n, h), int'(out_data), exp);
      check_eq($sformatf("n%0d_hold%0d_in_ready", n, h), int'(in_ready), 0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  initial begin
    reset        = 1'b0;
    start        = 1'b0;
    in_valid     = 1'b0;
    in_data      = '0;
    bias         = '0;
    out_ready    = 1'b0;
    w_index_mode = 1'b0;
    w_ov_en      = 1'b0;
    w_val        = '0;

    repeat (2) @(negedge clk);
    check_eq("rst_busy", int'(busy), 0);
    check_eq("rst_in_ready", int'(in_ready), 0);
    check_eq("rst_out_valid", int'(out_valid), 0);
    check_eq("rst_out_data", int'(out_data), 0);
    check_eq("rst_out_last", int'(out_last), 0);
    check_eq("rst_neuron_idx", int'(neuron_idx), 0);
    reset = 1'b1;
    @(negedge clk);

    // Pass 1: directed vectors, one per neuron.
    w_val = 16'sd1024;
    bias  = 16'sd512;
    pulse_start();
    check_eq("p1_busy", int'(busy), 1);
    feed(0, 1024, 1024, 3, 1'b0);
    take_out(0, 8704, 1'b0, 0);

    w_ov_en = 1'b1;
    feed(1, 1024, 1024, 3, 1'b0);
    take_out(1, 8704, 1'b0, 0);
    w_ov_en = 1'b0;

    w_val = 16'sd32767;
    bias  = 16'sd0;
    feed(2, 32767, 32767, 3, 1'b0);
    take_out(2, 32767, 1'b0, 0);

    feed(3, -32768, -32768, 3, 1'b0);
    take_out(3, relu_exp(-32768), 1'b0, 0);

    w_val = -16'sd512;
    bias  = 16'sd1024;
    feed(4, 2048, 2048, 3, 1'b0);
    take_out(4, relu_exp(-7168), 1'b0, 0);

    // Arithmetic shift floors: (1 * -1) >>> 10 = -1 per input.
    w_val = -16'sd1;
    bias  = 16'sd0;
    feed(5, 1, 1, 3, 1'b0);
    take_out(5, relu_exp(-8), 1'b0, 0);

    w_val = 16'sd1024;
    bias  = 16'sd512;
    feed(6, 1024, 1024, 3, 1'b0);
    take_out(6, 8704, 1'b0, 5);
    check_eq("bp_next_idx", int'(neuron_idx), 7);
    check_eq("bp_next_in_ready", int'(in_ready), 1);

    for (int n = 7; n < 16; n++) begin
      feed(n, 1024, 1024, 3, 1'b0);
      take_out(n, 8704, n == 15, 0);
    end
    check_eq("p1_end_busy", int'(busy), 0);
    check_eq("p1_end_idx", int'(neuron_idx), 0);
    check_eq("p1_end_out_valid", int'(out_valid), 0);

    // Pass 2: weight = flat index, data 1.0, so neuron n sums to 64n+28.
    w_index_mode = 1'b1;
    bias         = -16'sd100;
    @(negedge clk);
    pulse_start();
    for (int n = 0; n < 16; n++) begin
      if (n == 5) begin
        pulse_start();
        check_eq("p2_start_ignored_idx", int'(neuron_idx), 5);
        check_eq("p2_start_ignored_busy", int'(busy), 1);
      end
      feed(n, 1024, 1024, 3, 1'b1);
      take_out(n, relu_exp(64 * n - 72), n == 15, 0);
    end
    check_eq("p2_end_busy", int'(busy), 0);
    check_eq("p2_end_idx", int'(neuron_idx), 0);

    // Reset in the middle of a neuron, then a clean unity neuron.
    w_index_mode = 1'b0;
    w_val        = 16'sd1024;
    bias         = 16'sd512;
    pulse_start();
    feed(0, 5000, 5000, 2, 1'b0);
    reset = 1'b0;
    #1;
    check_eq("mid_rst_busy", int'(busy), 0);
    check_eq("mid_rst_in_ready", int'(in_ready), 0);
    check_eq("mid_rst_idx", int'(neuron_idx), 0);
    check_eq("mid_rst_out_valid", int'(out_valid), 0);
    check_eq("mid_rst_out_data", int'(out_data), 0);
    check_eq("mid_rst_waddr", int'(w_addr), 0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    pulse_start();
    feed(0, 1024, 1024, 3, 1'b0);
    take_out(0, 8704, 1'b0, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
